// File: rtl/mux_t_t_t_n.sv
// Race-logic gated multiplexer: each lane passes its event only if it strictly precedes the select event.
// Build option MUX_FALLING_EDGE_EN switches to falling-edge event coding (idle level 1).
module mux_t_t_t_n #(
  parameter int NUM_INPUTS = 4
) (
  input  logic                  aclk,
  input  logic                  grst_n,
  input  logic [NUM_INPUTS-1:0] inputs,
  input  logic                  select_line,
  output logic [NUM_INPUTS-1:0] y
);

`ifdef MUX_FALLING_EDGE_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif
  localparam logic ACT_LVL = ~IDLE_LVL;

  logic                  sel_seen_q, sel_seen_d;
  logic [NUM_INPUTS-1:0] y_q, y_d;
  logic                  sel_act;
  logic                  pass_win;

  assign sel_act    = (select_line == ACT_LVL);
  // Select wins ties: a lane sampled active together with the first select is blocked.
  assign pass_win   = ~sel_seen_q & ~sel_act;
  assign sel_seen_d = sel_seen_q | sel_act;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      assign y_d[gi] = (pass_win && (inputs[gi] == ACT_LVL)) ? ACT_LVL : y_q[gi];
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      sel_seen_q <= 1'b0;
      y_q        <= {NUM_INPUTS{IDLE_LVL}};
    end else begin
      sel_seen_q <= sel_seen_d;
      y_q        <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_mux_t_t_t_n.sv
// Scoreboard bench for mux_t_t_t_n: event-time reference model, directed scenarios and random traffic.
module tb_mux_t_t_t_n;
  localparam int N = 4;
`ifdef MUX_FALLING_EDGE_EN
  localparam logic IDLE = 1'b1;
`else
  localparam logic IDLE = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         grst_n;
  logic [N-1:0] inputs;
  logic         select_line;
  logic [N-1:0] y;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] sb_q[$];

  // Reference model state: cycle index of first active sample per lane and for select (-1 = none yet).
  int cyc;
  int in_t[N];
  int sel_t;

  mux_t_t_t_n #(.NUM_INPUTS(N)) dut (
    .aclk       (aclk),
    .grst_n     (grst_n),
    .inputs     (inputs),
    .select_line(select_line),
    .y          (y)
  );

  always #5 aclk = ~aclk;

  function automatic logic [N-1:0] to_act(input logic [N-1:0] raw);
    return raw ^ {N{IDLE}};
  endfunction

  // Drive one sample period (active-coded), advance the model and queue the expected output.
  task automatic step(input logic rst_n, input logic [N-1:0] in_act, input logic sel_act);
    logic [N-1:0] exp_act;
    @(negedge aclk);
    grst_n      = rst_n;
    inputs      = in_act ^ {N{IDLE}};
    select_line = sel_act ^ IDLE;
    exp_act     = '0;
    if (!rst_n) begin
      cyc   = 0;
      sel_t = -1;
      for (int i = 0; i < N; i++) in_t[i] = -1;
    end else begin
      cyc++;
      if (sel_act && sel_t < 0) sel_t = cyc;
      for (int i = 0; i < N; i++) begin
        if (in_act[i] && in_t[i] < 0) in_t[i] = cyc;
        exp_act[i] = (in_t[i] >= 0) && (sel_t < 0 || in_t[i] < sel_t);
      end
    end
    sb_q.push_back(exp_act);
  endtask

  task automatic expect_y(input string name, input logic [N-1:0] exp_act);
    @(posedge aclk);
    #2;
    n_cmp++;
    if (to_act(y) !== exp_act) begin
      n_bad++;
      $display("FAIL %s: y(active)=%b required=%b", name, to_act(y), exp_act);
    end else
      $display("ok   %s: y(active)=%b", name, to_act(y));
  endtask

  // Monitor: one registered output per clock edge, compared against the queued expectation.
  initial begin
    logic [N-1:0] e;
    forever begin
      @(posedge aclk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (to_act(y) !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: y(active)=%b required=%b", $time, to_act(y), e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] cur;
    logic         s;
    grst_n      = 1'b0;
    inputs      = {N{IDLE}};
    select_line = IDLE;

    // Reset state
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_y("reset_idle", 4'b0000);

    // Input before select, later events blocked
    step(1'b0, '0, 1'b0);
    cur = 4'b0001;
    for (int k = 0; k < 10; k++) step(1'b1, cur, 1'b0);
    cur |= 4'b0010;
    for (int k = 0; k < 10; k++) step(1'b1, cur, 1'b1);
    cur |= 4'b0100;
    for (int k = 0; k < 5; k++) step(1'b1, cur, 1'b1);
    expect_y("before_select", 4'b0001);

    // Tie and late event
    step(1'b0, '0, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b1001, 1'b1);
    step(1'b1, 4'b1101, 1'b1);
    expect_y("tie_and_late", 4'b0001);

    // No late inputs
    step(1'b0, '0, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0101, 1'b1);
    expect_y("no_late", 4'b0001);

    // All lanes before select
    step(1'b0, '0, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    expect_y("all_lanes", 4'b1111);

    // Reset mid-cycle, then fresh event
    step(1'b0, '0, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    step(1'b1, 4'b0011, 1'b1);
    expect_y("pre_reset", 4'b0011);
    step(1'b0, 4'b0011, 1'b1);
    expect_y("mid_reset", 4'b0000);
    step(1'b1, 4'b0100, 1'b0);
    expect_y("after_reset", 4'b0100);

    // Select first blocks everything
    step(1'b0, '0, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    expect_y("select_first", 4'b0000);

    // Single-event latency: not visible before the edge, visible right after it
    step(1'b0, '0, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    @(negedge aclk);
    grst_n = 1'b1;
    inputs = 4'b1000 ^ {N{IDLE}};
    select_line = IDLE;
    cyc++;
    in_t[3] = cyc;
    sb_q.push_back(4'b1000);
    #1;
    n_cmp++;
    if (to_act(y) !== 4'b0000) begin
      n_bad++;
      $display("FAIL latency_pre: y(active)=%b required=0000", to_act(y));
    end
    expect_y("latency_post", 4'b1000);

    // Falling-edge build scenario (identical in active coding)
    step(1'b0, '0, 1'b0);
    expect_y("reset_again", 4'b0000);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0011, 1'b1);
    expect_y("edge_seq", 4'b0001);

    // Random traffic, including reset with inputs held across release
    cur = '0;
    s   = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        cur = 4'($urandom);
        s   = ($urandom_range(0, 3) == 0);
        step(1'b0, cur, s);
      end else begin
        if ($urandom_range(0, 3) == 0) cur = cur | (4'b0001 << $urandom_range(0, N - 1));
        if ($urandom_range(0, 15) == 0) cur = cur & ~(4'b0001 << $urandom_range(0, N - 1));
        if ($urandom_range(0, 11) == 0) s = 1'b1;
        step(1'b1, cur, s);
      end
    end

    @(posedge aclk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_t_t_t_n.md
# mux_t_t_t_n

Temporal (race-logic) gated multiplexer: `NUM_INPUTS` transition-coded input lanes and one transition-coded select line, producing `NUM_INPUTS` transition-coded outputs. Each lane forwards its input event to its output only if the event arrives strictly before the select event. Once the select event occurs, the block switches from "pass" to "block" for the rest of the gamma cycle. It sits in the temporal datapath between spike/edge sources and downstream race-logic operators (min/max/inhibit), and is cleared between gamma cycles by the global reset.

## Interface
Parameters:
- `NUM_INPUTS`, default 4. Number of lanes (≥1). Sets the width of `inputs` and `y`.

Ports:
- `aclk` (in, 1): single clock. All state updates on its rising edge.
- `grst_n` (in, 1): reset, synchronous, active-low. Also marks the gamma-cycle boundary.
- `inputs` (in, `NUM_INPUTS`): per-lane temporal event.
  - An event is the transition away from the idle level.
  - After an event, the source holds the active level until reset.
- `select_line` (in, 1): temporal select event, same coding as `inputs`.
- `y` (out, `NUM_INPUTS`): per-lane output event. Registered and sticky until reset.

## Operation
- Idle level is 0 and an event is a 0→1 transition (default build; see Configuration).
- Internal state, all registered:
  - `sel_seen` (1 bit): sticky record that the select event has occurred.
  - `y_q` (`NUM_INPUTS` bits): sticky output state.
- Two states, PASS (`sel_seen`=0) and BLOCK (`sel_seen`=1).
  - PASS→BLOCK on the first clock edge that samples `select_line` active.
  - BLOCK persists until reset. There is no return to PASS otherwise.
- Per-lane update at each clock edge, with `grst_n`=1: `y_q[i]` is set to 1 if all of the following hold:
  - `inputs[i]` is sampled active;
  - `sel_seen`=0;
  - `select_line` is sampled inactive in that same cycle.
  Otherwise `y_q[i]` holds.
- Simultaneous events: an input sampled active in the same cycle as the first active `select_line` is blocked (select wins ties).
- Once set, `y[i]` stays 1 regardless of later input or select activity. Inputs dropping back to idle mid-cycle have no effect.
- An input that arrives after the select event never produces an output event in that gamma cycle.
- Lanes are fully independent. Any subset, including all or none, may fire.
- `y = y_q`. There is no combinational path from inputs to outputs.

## Timing
- Reset: with `grst_n`=0 at a clock edge, `sel_seen`←0 and `y_q`←all idle level (0 by default).
  - Reset dominates every simultaneous event.
  - Reset mid-operation discards all state.
- Reset release: the first edge with `grst_n`=1 already evaluates events. An input held active across reset release fires on that edge, unless select is also active.
- Latency: an input sampled active at edge k gives `y[i]`=1 immediately after edge k (1-cycle registered latency, measured from the input settling before the edge).
- Event ordering is resolved at clock granularity. Two events landing in the same sample period are treated as simultaneous.
- Inputs are assumed synchronous to `aclk`. No internal synchronizers.

## Configuration
- `MUX_FALLING_EDGE_EN`:
  - Defined: events are 1→0 transitions. Idle level of `inputs`, `select_line` and `y` is 1. Reset drives `y` to all-ones. The active level is 0 everywhere in the rules above.
  - Undefined: rising-edge coding as described above (idle 0, reset `y`=0).

## Test plan
- Input before select: reset, lane 0 active, 10 cycles later select active plus lane 1 active, 10 cycles later lane 2 active → `y`=4'b0001, stable until reset.
- Tie and late event: reset, lane 0 active, then lane 3 and select active in the same cycle, then lane 2 active → `y`=4'b0001 (lane 3 blocked by tie, lane 2 blocked as late).
- No late inputs: reset, lane 0 active, select active, lane 2 active → `y`=4'b0001. Also: all four lanes active before select → `y`=4'b1111 one cycle after sampling.
- Reset mid-cycle: with `y`=4'b0011 and `sel_seen`=1, pulse `grst_n`=0 for one edge → `y`=4'b0000. Then lane 2 active with select idle → `y`=4'b0100.
- Select first: reset, select active, then all lanes active → `y` stays 4'b0000. Also check the 1-cycle latency of a single pass event.
- `MUX_FALLING_EDGE_EN` build: reset → `y`=4'b1111. Lane 0 falls, then select falls, then lane 1 falls → `y`=4'b1110.
